character_action_controller: RTL and testbench

CHARACTER_ACTION_CONTROLLER -- requirements
Module: character_action_controller

---
 rtl/character_action_controller.sv | 182 ++++++++++++++++++
 tb/tb_character_action_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/character_action_controller.sv
// Character action controller: turns button levels and physics feedback into
// a movement/jump state machine, issuing a single launch request per jump.
// Optional feature macro: CHAR_PAUSE_EN adds a pause input and the HOLD state.
module character_action_controller #(
  parameter int unsigned SIGNED_PHY_WIDTH = 17,
  parameter int unsigned MAX_CHARGE       = 32,
  parameter int unsigned JUMP_BASE        = 2,
  parameter int unsigned MAX_VEL_Y        = 10,
  parameter int unsigned JUMP_VEL_X       = 4,
  parameter int unsigned LAND_TICKS       = 16
) (
  input  logic                                  sys_clk,
  input  logic                                  sys_rst_n,
  input  logic                                  character_clk,
  input  logic                                  btn_left,
  input  logic                                  btn_right,
  input  logic                                  btn_jump,
  input  logic                                  on_ground,
  input  logic                                  hit_wall,
  input  logic signed [SIGNED_PHY_WIDTH-1:0]    vel_y,
`ifdef CHAR_PAUSE_EN
  input  logic                                  pause,
`endif
  output logic [2:0]                            char_state,
  output logic                                  jump_req,
  output logic signed [SIGNED_PHY_WIDTH-1:0]    jump_vel_y,
  output logic signed [SIGNED_PHY_WIDTH-1:0]    jump_vel_x,
  output logic [$clog2(MAX_CHARGE+1)-1:0]       charge_level
);

  localparam int unsigned W  = SIGNED_PHY_WIDTH;
  localparam int unsigned CW = $clog2(MAX_CHARGE + 1);
  localparam int unsigned LW = (LAND_TICKS > 1) ? $clog2(LAND_TICKS) : 1;

  localparam logic [CW-1:0]       CHARGE_MAX = CW'(MAX_CHARGE);
  localparam logic [LW-1:0]       LAND_LAST  = LW'(LAND_TICKS - 1);
  localparam logic [31:0]         VEL_Y_CAP  = 32'(MAX_VEL_Y);
  localparam logic signed [W-1:0] VEL_X_MAG  = W'(JUMP_VEL_X);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LEFT      = 3'd1,
    ST_RIGHT     = 3'd2,
    ST_CHARGE    = 3'd3,
    ST_JUMP      = 3'd4,
    ST_COLLISION = 3'd5,
    ST_FALL      = 3'd6,
    ST_HOLD      = 3'd7
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         charge_q, charge_d;
  logic [LW-1:0]         land_q, land_d;
  logic                  dir_q, dir_d;
  logic signed [W-1:0]   vel_y_q, vel_y_d;
  logic signed [W-1:0]   vel_x_q, vel_x_d;
  logic                  launch_c;
  logic [31:0]           vy_sum_c;
  logic                  dir_left_c, dir_right_c, landing_c;
`ifdef CHAR_PAUSE_EN
  state_t                saved_q, saved_d;
`endif

  // Direction decode: both buttons cancel out; landing needs support and no upward motion.
  assign dir_left_c  = btn_left & ~btn_right;
  assign dir_right_c = btn_right & ~btn_left;
  assign landing_c   = on_ground & (vel_y[W-1] | (vel_y == '0));

  assign char_state   = state_q;
  assign charge_level = charge_q;
  assign jump_vel_y   = vel_y_q;
  assign jump_vel_x   = vel_x_q;

  // Next-state, counter and launch-velocity evaluation for one physics tick.
  always_comb begin
    state_d  = state_q;
    charge_d = charge_q;
    land_d   = land_q;
    dir_d    = dir_q;
    vel_y_d  = vel_y_q;
    vel_x_d  = vel_x_q;
    launch_c = 1'b0;
    vy_sum_c = 32'(JUMP_BASE) + 32'(charge_q);
`ifdef CHAR_PAUSE_EN
    saved_d  = saved_q;
    if (pause) begin
      if (state_q != ST_HOLD) saved_d = state_q;
      state_d = ST_HOLD;
    end else
`endif
    begin
      case (state_q)
        ST_IDLE, ST_LEFT, ST_RIGHT: begin
          if (!on_ground) begin
            state_d = ST_JUMP;
          end else if (btn_jump) begin
            state_d  = ST_CHARGE;
            charge_d = '0;
          end else if (dir_left_c) begin
            state_d = ST_LEFT;
          end else if (dir_right_c) begin
            state_d = ST_RIGHT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CHARGE: begin
          if (!btn_jump || (charge_q == CHARGE_MAX)) begin
            state_d  = ST_JUMP;
            launch_c = 1'b1;
            vel_y_d  = (vy_sum_c > VEL_Y_CAP) ? W'(VEL_Y_CAP) : W'(vy_sum_c);
            vel_x_d  = dir_left_c ? -VEL_X_MAG : (dir_right_c ? VEL_X_MAG : '0);
            dir_d    = dir_left_c;
          end else begin
            charge_d = charge_q + CW'(1);
          end
        end
        ST_JUMP: begin
          if (landing_c) begin
            state_d = ST_FALL;
            land_d  = '0;
          end else if (hit_wall) begin
            state_d = ST_COLLISION;
            dir_d   = ~dir_q;
          end
        end
        ST_COLLISION: begin
          if (landing_c) begin
            state_d = ST_FALL;
            land_d  = '0;
          end else begin
            state_d = ST_JUMP;
          end
        end
        ST_FALL: begin
          if (land_q == LAND_LAST) begin
            state_d = ST_IDLE;
          end else begin
            land_d = land_q + LW'(1);
          end
        end
        ST_HOLD: begin
`ifdef CHAR_PAUSE_EN
          state_d = saved_q;
`else
          state_d = ST_IDLE;
`endif
        end
      endcase
    end
  end

  // Registers advance only on physics ticks; jump_req is a single-cycle pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      charge_q <= '0;
      land_q   <= '0;
      dir_q    <= 1'b0;
      vel_y_q  <= '0;
      vel_x_q  <= '0;
      jump_req <= 1'b0;
`ifdef CHAR_PAUSE_EN
      saved_q  <= ST_IDLE;
`endif
    end else begin
      jump_req <= character_clk & launch_c;
      if (character_clk) begin
        state_q  <= state_d;
        charge_q <= charge_d;
        land_q   <= land_d;
        dir_q    <= dir_d;
        vel_y_q  <= vel_y_d;
        vel_x_q  <= vel_x_d;
`ifdef CHAR_PAUSE_EN
        saved_q  <= saved_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_character_action_controller.sv
// Scoreboard bench for character_action_controller: stimulus pushes expected
// per-tick results and launches from a behavioural model; a monitor compares.
module tb_character_action_controller;

  localparam int W          = 17;
  localparam int MAX_CHARGE = 32;
  localparam int JUMP_BASE  = 2;
  localparam int MAX_VEL_Y  = 10;
  localparam int JUMP_VEL_X = 4;
  localparam int LAND_TICKS = 16;
  localparam int CW         = $clog2(MAX_CHARGE + 1);

  logic                sys_clk = 1'b0;
  logic                sys_rst_n = 1'b0;
  logic                character_clk = 1'b0;
  logic                btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic                on_ground = 1'b1, hit_wall = 1'b0;
  logic signed [W-1:0] vel_y = '0;
  logic                pause = 1'b0;
  logic [2:0]          char_state;
  logic                jump_req;
  logic signed [W-1:0] jump_vel_y, jump_vel_x;
  logic [CW-1:0]       charge_level;

  character_action_controller dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .character_clk (character_clk),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_jump      (btn_jump),
    .on_ground     (on_ground),
    .hit_wall      (hit_wall),
    .vel_y         (vel_y),
`ifdef CHAR_PAUSE_EN
    .pause         (pause),
`endif
    .char_state    (char_state),
    .jump_req      (jump_req),
    .jump_vel_y    (jump_vel_y),
    .jump_vel_x    (jump_vel_x),
    .charge_level  (charge_level)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int st;
    int chg;
    bit req;
    int vy;
    int vx;
  } exp_t;

  typedef struct {
    int vy;
    int vx;
  } launch_t;

  exp_t    tick_q[$];
  launch_t launch_q[$];
  int      checks = 0;
  int      failures = 0;

  // Behavioural model state (spec state codes, plain integers).
  int m_state, m_charge, m_land, m_vy, m_vx, m_saved;

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, expv);
    end
  endfunction

  function automatic void model_reset();
    m_state = 0; m_charge = 0; m_land = 0; m_vy = 0; m_vx = 0; m_saved = 0;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // One physics tick of the reference behaviour; returns 1 when a launch happens.
  function automatic bit model_step(bit l, bit r, bit j, bit g, bit w, int vy, bit p);
    int  dir  = int'(r) - int'(l);
    bit  land = g && (vy <= 0);
    bit  launch = 1'b0;
`ifdef CHAR_PAUSE_EN
    if (p) begin
      if (m_state != 7) m_saved = m_state;
      m_state = 7;
      return 1'b0;
    end
    if (m_state == 7) begin
      m_state = m_saved;
      return 1'b0;
    end
`endif
    case (m_state)
      0, 1, 2: begin
        if (!g) m_state = 4;
        else if (j) begin m_state = 3; m_charge = 0; end
        else m_state = (dir < 0) ? 1 : ((dir > 0) ? 2 : 0);
      end
      3: begin
        if (!j || m_charge == MAX_CHARGE) begin
          launch  = 1'b1;
          m_vy    = imin(JUMP_BASE + m_charge, MAX_VEL_Y);
          m_vx    = dir * JUMP_VEL_X;
          m_state = 4;
        end else begin
          m_charge++;
        end
      end
      4: begin
        if (land) begin m_state = 6; m_land = 0; end
        else if (w) m_state = 5;
      end
      5: begin
        if (land) begin m_state = 6; m_land = 0; end
        else m_state = 4;
      end
      6: begin
        if (m_land == LAND_TICKS - 1) m_state = 0;
        else m_land++;
      end
      default: m_state = 0;
    endcase
    return launch;
  endfunction

  // Drive one tick (called at posedge+2), record expectations, advance one cycle.
  task automatic do_tick(input bit l, input bit r, input bit j, input bit g,
                         input bit w, input int vy, input bit p);
    exp_t    e;
    launch_t lr;
    bit      launch;
    btn_left = l; btn_right = r; btn_jump = j; on_ground = g; hit_wall = w;
    vel_y = W'(vy); pause = p; character_clk = 1'b1;
    launch = model_step(l, r, j, g, w, vy, p);
    e.st = m_state; e.chg = m_charge; e.req = launch; e.vy = m_vy; e.vx = m_vx;
    tick_q.push_back(e);
    if (launch) begin
      lr.vy = m_vy; lr.vx = m_vx;
      launch_q.push_back(lr);
    end
    @(posedge sys_clk); #2;
    character_clk = 1'b0;
  endtask

  // Non-tick cycles with random input noise that must be ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      btn_left = 1'($urandom); btn_right = 1'($urandom); btn_jump = 1'($urandom);
      on_ground = 1'($urandom); hit_wall = 1'($urandom); pause = 1'($urandom);
      vel_y = W'(int'($urandom_range(0, 10)) - 5);
      @(posedge sys_clk); #2;
    end
  endtask

  task automatic do_reset();
    character_clk = 1'b0;
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b0;
    model_reset();
    @(posedge sys_clk); #2;
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b1;
  endtask

  // Monitor: compare at negedge; pop per-tick expectations and launch records.
  initial begin : monitor
    exp_t    last_e;
    exp_t    e;
    launch_t lr;
    bit      was_tick;
    last_e = '{st: 0, chg: 0, req: 1'b0, vy: 0, vx: 0};
    forever begin
      @(posedge sys_clk);
      was_tick = character_clk && sys_rst_n;
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        chk("rst_state", int'(char_state), 0);
        chk("rst_jump_req", int'(jump_req), 0);
        chk("rst_vel_y", int'(jump_vel_y), 0);
        chk("rst_vel_x", int'(jump_vel_x), 0);
        chk("rst_charge", int'(charge_level), 0);
        last_e = '{st: 0, chg: 0, req: 1'b0, vy: 0, vx: 0};
      end else if (was_tick) begin
        if (tick_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tick_queue_empty at %0t: actual=empty expected=record", $time);
        end else begin
          e = tick_q.pop_front();
          chk("tick_state", int'(char_state), e.st);
          chk("tick_charge", int'(charge_level), e.chg);
          chk("tick_jump_req", int'(jump_req), int'(e.req));
          chk("tick_vel_y", int'(jump_vel_y), e.vy);
          chk("tick_vel_x", int'(jump_vel_x), e.vx);
          last_e = e;
        end
      end else begin
        chk("hold_state", int'(char_state), last_e.st);
        chk("hold_charge", int'(charge_level), last_e.chg);
        chk("hold_jump_req", int'(jump_req), 0);
        chk("hold_vel_y", int'(jump_vel_y), last_e.vy);
        chk("hold_vel_x", int'(jump_vel_x), last_e.vx);
      end
      if (sys_rst_n && jump_req === 1'b1) begin
        if (launch_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_jump_req at %0t: actual=1 expected=0", $time);
        end else begin
          lr = launch_q.pop_front();
          chk("launch_vel_y", int'(jump_vel_y), lr.vy);
          chk("launch_vel_x", int'(jump_vel_x), lr.vx);
        end
      end
    end
  end

  initial begin : stimulus
    model_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b1;
    idle_cycles(2);

    // Both directions cancel; left alone moves left.
    do_tick(1, 1, 0, 1, 0, 0, 0);
    do_tick(1, 0, 0, 1, 0, 0, 0);
    do_tick(0, 1, 0, 1, 0, 0, 0);
    do_tick(0, 0, 0, 1, 0, 0, 0);

    // Short charge: enter, five charging ticks, release -> vel_y 7, vel_x 0.
    do_tick(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      do_tick(0, 0, 1, 1, 0, 0, 0);
      idle_cycles(1);
    end
    do_tick(0, 0, 0, 1, 0, 0, 0);

    // Airborne, wall hit, collision recovery, then simultaneous wall + landing.
    do_tick(0, 0, 0, 0, 0, 4, 0);
    do_tick(0, 0, 0, 0, 1, 2, 0);
    do_tick(0, 0, 0, 0, 0, 1, 0);
    do_tick(0, 0, 0, 0, 0, 0, 0);
    do_tick(0, 0, 0, 1, 1, -3, 0);

    // Jump held during landing is ignored until IDLE, then charges.
    for (int i = 0; i < LAND_TICKS; i++) do_tick(0, 0, 1, 1, 0, 0, 0);
    do_tick(0, 0, 1, 1, 0, 0, 0);
    do_tick(0, 0, 0, 1, 0, 0, 0);
    do_tick(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < LAND_TICKS; i++) do_tick(0, 0, 0, 1, 0, 0, 0);

    // Long charge with right held: saturates and auto-launches exactly once.
    for (int i = 0; i < 40; i++) do_tick(0, 1, 1, 1, 0, 5, 0);
    do_tick(0, 0, 0, 1, 0, -1, 0);
    for (int i = 0; i < LAND_TICKS; i++) do_tick(0, 0, 0, 1, 0, 0, 0);

    // Reset mid-charge at level 9 aborts without a launch, resumes from IDLE.
    do_tick(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) do_tick(0, 0, 1, 1, 0, 0, 0);
    do_reset();
    do_tick(0, 0, 0, 1, 0, 0, 0);

`ifdef CHAR_PAUSE_EN
    // Pause mid-charge and resume; charge continues from the saved level.
    do_tick(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) do_tick(0, 0, 1, 1, 0, 0, 0);
    do_tick(0, 0, 0, 1, 0, 0, 1);
    do_tick(0, 0, 0, 1, 0, 0, 1);
    do_tick(0, 0, 1, 1, 0, 0, 0);
    do_tick(0, 0, 1, 1, 0, 0, 0);
    do_tick(0, 0, 0, 1, 0, 0, 0);
`endif

    // Randomized ticks with noisy gaps and occasional resets.
    for (int n = 0; n < 800; n++) begin
      bit p;
      p = 1'b0;
`ifdef CHAR_PAUSE_EN
      p = ($urandom_range(0, 15) == 0);
`endif
      do_tick(1'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
              int'($urandom_range(0, 10)) - 5, p);
      idle_cycles(int'($urandom_range(0, 2)));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    idle_cycles(3);
    chk("tick_queue_drained", tick_q.size(), 0);
    chk("launch_queue_drained", launch_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
